ysyx_23060059_wbu: RTL
======================

Name: ysyx_23060059_wbu

Overview:
Write-back stage that consumes retired instructions from the load/store stage over a valid/ready handshake. It owns the general-purpose register file and the four machine CSRs (mstatus, mtvec, mepc, mcause), and commits register and CSR updates. It also handles ecall and ebreak side effects. It exports combinational read ports and an in-flight destination tag, which the decode stage uses for operand fetch and hazard detection. It emits a one-cycle commit pulse used for difftest and trace.

Parameters:
GPR_NUM  32  number of GPRs; legal values 16 or 32; rd/rs index bits above log2(GPR_NUM) are ignored
RESET_MSTATUS  32'h00001800  reset value of mstatus
ECALL_CAUSE  32'd11  value written to mcause on ecall

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
receive_valid  in  1  upstream instruction valid; held until accepted
send_ready  out  1  wbu can accept an instruction
wd_i  in  32  GPR write data
csr_wd_i  in  32  CSR write data
rd_i  in  5  GPR destination
csr_rd_i  in  2  CSR destination: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
reg_en_i  in  1  GPR write enable
csreg_en_i  in  1  CSR write enable
pc_i  in  32  instruction pc
pc_next_i  in  32  successor pc
instruction_i  in  32  instruction word
ecall_i  in  1  instruction is ecall
ebreak_i  in  1  instruction is ebreak
rs1_addr  in  5  read port 1 index
rs2_addr  in  5  read port 2 index
rs1_data  out  32  read port 1 data
rs2_data  out  32  read port 2 data
csr_raddr  in  2  CSR read index
csr_rdata  out  32  CSR read data
rd_wbu_to_idu  out  5  in-flight GPR destination, 0 if none
csr_rd_wbu_to_idu  out  2  in-flight CSR destination
csr_busy  out  1  an in-flight CSR write or ecall is pending
commit_valid  out  1  one-cycle retire pulse
commit_pc  out  32  retired pc
commit_pc_next  out  32  retired successor pc
commit_instr  out  32  retired instruction
halted  out  1  sticky ebreak flag

Behaviour:
- FSM states: IDLE, WRITE, DONE.
  - IDLE: send_ready = !halted.
  - Accept condition: receive_valid && send_ready. On accept, latch all *_i inputs into internal holding registers and go to WRITE.
  - WRITE: perform the architectural writes at the clock edge leaving WRITE, then go to DONE.
  - DONE: commit_valid = 1 for exactly one cycle, then go to IDLE.
- send_ready = 0 in WRITE and DONE. Throughput is one instruction per 3 cycles. There is no buffering; upstream holds its data.
- GPR write: when reg_en is latched and rd != 0, regfile[rd] <= wd. Writes to x0 are dropped and x0 always reads 0.
- CSR write: when csreg_en is latched, csr[csr_rd] <= csr_wd.
- ecall: mepc <= pc and mcause <= ECALL_CAUSE. If csreg_en is set in the same instruction and targets mepc or mcause, the ecall values win. A csreg_en write to mstatus or mtvec still happens.
- ebreak: halted <= 1 at the WRITE edge. The GPR/CSR writes of that instruction still occur, and DONE still pulses commit_valid. Afterwards send_ready stays 0 until reset.
- Reads are combinational. During WRITE, a read whose index matches the pending write returns the new value (write-first forwarding); this applies to both GPR ports and the CSR port. rs index 0 always returns 0.
- rd_wbu_to_idu = latched rd when state != IDLE and reg_en is latched, else 0.
- csr_rd_wbu_to_idu = latched csr_rd when state != IDLE, else 0.
- csr_busy = (state != IDLE) && (csreg_en || ecall).
- commit_pc, commit_pc_next and commit_instr are driven from the holding registers. They are stable from WRITE through DONE and hold their value in IDLE.
- Reset values:
  - state IDLE; send_ready 0 in the reset cycle, then 1 afterwards.
  - commit_valid 0; commit_* 0; halted 0; rd/csr tags 0; csr_busy 0.
  - GPRs 0; mstatus RESET_MSTATUS; mtvec, mepc, mcause 0.
- Reset asserted in WRITE: the pending write is discarded, no commit occurs, and the FSM returns to IDLE.
- receive_valid deasserting in IDLE before acceptance is legal; nothing is latched.
- Input changes while in WRITE or DONE are ignored.

Test Plan:
- Reset release, then addi result: receive_valid with rd=5, wd=0x1234, reg_en=1 -> accepted in 1 cycle; send_ready=0 for 2 cycles; commit_valid pulses on the 3rd cycle with commit_pc=pc_i; rs1_addr=5 then reads 0x1234.
- rd=0 with wd=0xdeadbeef and reg_en=1 -> x0 reads 0; commit_valid still pulses.
- Forwarding: rs2_addr=7 held while an instruction writes x7=0xa5a5a5a5 -> rs2_data=0xa5a5a5a5 during WRITE, the same cycle the write is pending; rd_wbu_to_idu=7 during WRITE and DONE, 0 in IDLE.
- ecall at pc=0x80000010, combined with a csreg_en write of 0x55 to mepc -> mepc=0x80000010, mcause=11; csr_busy=1 for 2 cycles.
- csrw mtvec=0x80000100 -> csr_rdata with csr_raddr=1 returns 0x80000100 from WRITE onward; mstatus reads 0x1800 after reset.
- ebreak at pc=0x80000020 -> commit_valid pulses; halted=1; send_ready stays 0 with receive_valid held high for 10 cycles; reset clears halted and restores send_ready.

Source files
------------

// File: rtl/ysyx_23060059_wbu_if.sv
// Upstream load/store-to-writeback handshake and retired-instruction payload.
interface ysyx_23060059_wbu_if;
  logic        receive_valid;
  logic        send_ready;
  logic [31:0] wd_i;
  logic [31:0] csr_wd_i;
  logic [4:0]  rd_i;
  logic [1:0]  csr_rd_i;
  logic        reg_en_i;
  logic        csreg_en_i;
  logic [31:0] pc_i;
  logic [31:0] pc_next_i;
  logic [31:0] instruction_i;
  logic        ecall_i;
  logic        ebreak_i;

  modport master (
    output receive_valid, wd_i, csr_wd_i, rd_i, csr_rd_i, reg_en_i, csreg_en_i,
           pc_i, pc_next_i, instruction_i, ecall_i, ebreak_i,
    input  send_ready
  );

  modport slave (
    input  receive_valid, wd_i, csr_wd_i, rd_i, csr_rd_i, reg_en_i, csreg_en_i,
           pc_i, pc_next_i, instruction_i, ecall_i, ebreak_i,
    output send_ready
  );
endinterface

// File: rtl/ysyx_23060059_wbu.sv
// Write-back stage: owns GPRs and machine CSRs, commits one retired instruction
// per three cycles, and exports forwarded read ports plus hazard tags to decode.
//
// state | meaning
// IDLE  | ready for a new instruction (unless halted)
// WRITE | holding registers valid; architectural writes happen on exit edge
// DONE  | commit_valid pulse for the retired instruction
module ysyx_23060059_wbu #(
  parameter int          GPR_NUM       = 32,
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter logic [31:0] ECALL_CAUSE   = 32'd11
) (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_23060059_wbu_if.slave    up,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [31:0]           rs1_data,
  output logic [31:0]           rs2_data,
  input  logic [1:0]            csr_raddr,
  output logic [31:0]           csr_rdata,
  output logic [4:0]            rd_wbu_to_idu,
  output logic [1:0]            csr_rd_wbu_to_idu,
  output logic                  csr_busy,
  output logic                  commit_valid,
  output logic [31:0]           commit_pc,
  output logic [31:0]           commit_pc_next,
  output logic [31:0]           commit_instr,
  output logic                  halted
);
  localparam int IW = $clog2(GPR_NUM);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] h_wd, h_csr_wd, h_pc, h_pc_next, h_instr;
  logic [4:0]  h_rd;
  logic [1:0]  h_csr_rd;
  logic        h_reg_en, h_csreg_en, h_ecall, h_ebreak;

  logic [31:0] gpr [GPR_NUM];
  logic [31:0] csr_q [4];
  logic [31:0] csr_new [4];

  logic accept, in_write, gpr_we;

  assign accept   = up.receive_valid && up.send_ready;
  assign in_write = (state == WRITE);
  assign gpr_we   = in_write && h_reg_en && (h_rd[IW-1:0] != '0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    up.send_ready = 1'b0;
    commit_valid  = 1'b0;
    case (state)
      IDLE: begin
        up.send_ready = !halted && !reset;
        if (up.receive_valid && !halted) state_nxt = WRITE;
      end
      WRITE: state_nxt = DONE;
      DONE: begin
        commit_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_wd       <= '0;
      h_csr_wd   <= '0;
      h_pc       <= '0;
      h_pc_next  <= '0;
      h_instr    <= '0;
      h_rd       <= '0;
      h_csr_rd   <= '0;
      h_reg_en   <= 1'b0;
      h_csreg_en <= 1'b0;
      h_ecall    <= 1'b0;
      h_ebreak   <= 1'b0;
    end else if (accept) begin
      h_wd       <= up.wd_i;
      h_csr_wd   <= up.csr_wd_i;
      h_pc       <= up.pc_i;
      h_pc_next  <= up.pc_next_i;
      h_instr    <= up.instruction_i;
      h_rd       <= up.rd_i;
      h_csr_rd   <= up.csr_rd_i;
      h_reg_en   <= up.reg_en_i;
      h_csreg_en <= up.csreg_en_i;
      h_ecall    <= up.ecall_i;
      h_ebreak   <= up.ebreak_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < GPR_NUM; i++) gpr[i] <= '0;
    end else if (gpr_we) begin
      gpr[h_rd[IW-1:0]] <= h_wd;
    end
  end

  // ecall's mepc/mcause are applied last so they override a same-instruction csrw.
  always_comb begin
    for (int k = 0; k < 4; k++) csr_new[k] = csr_q[k];
    if (h_csreg_en) csr_new[h_csr_rd] = h_csr_wd;
    if (h_ecall) begin
      csr_new[2] = h_pc;
      csr_new[3] = ECALL_CAUSE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csr_q[0] <= RESET_MSTATUS;
      csr_q[1] <= '0;
      csr_q[2] <= '0;
      csr_q[3] <= '0;
    end else if (in_write) begin
      for (int k = 0; k < 4; k++) csr_q[k] <= csr_new[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                    halted <= 1'b0;
    else if (in_write && h_ebreak) halted <= 1'b1;
  end

  // Write-first forwarding while the write is pending in WRITE.
  always_comb begin
    if (rs1_addr[IW-1:0] == '0)                        rs1_data = '0;
    else if (gpr_we && rs1_addr[IW-1:0] == h_rd[IW-1:0]) rs1_data = h_wd;
    else                                                 rs1_data = gpr[rs1_addr[IW-1:0]];

    if (rs2_addr[IW-1:0] == '0)                        rs2_data = '0;
    else if (gpr_we && rs2_addr[IW-1:0] == h_rd[IW-1:0]) rs2_data = h_wd;
    else                                                 rs2_data = gpr[rs2_addr[IW-1:0]];

    csr_rdata = in_write ? csr_new[csr_raddr] : csr_q[csr_raddr];
  end

  assign rd_wbu_to_idu     = (state != IDLE && h_reg_en) ? h_rd : 5'd0;
  assign csr_rd_wbu_to_idu = (state != IDLE) ? h_csr_rd : 2'd0;
  assign csr_busy          = (state != IDLE) && (h_csreg_en || h_ecall);
  assign commit_pc         = h_pc;
  assign commit_pc_next    = h_pc_next;
  assign commit_instr      = h_instr;
endmodule
